// File: rtl/mbssoc_bus_arbiter_pkg.sv
// Shared constants and types for the SoC RAM bus arbiter and its round-robin picker.
// The optional starvation monitor is enabled with MBSSOC_ARB_STARVE_CNT_EN.
package mbssoc_bus_arbiter_pkg;

   localparam int ARB_CORE_NUM   = 2;
   localparam int ARB_ADDR_WIDTH = 32;
   localparam int ARB_DATA_WIDTH = 32;
   localparam int ARB_MAX_HOLD   = 16;
   localparam int CORE_IDX_WIDTH = $clog2(ARB_CORE_NUM);
   localparam int STARVE_WIDTH   = 16;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_OWN  = 1'b1
   } arb_state_e;

   // Index width that stays at least one bit wide for degenerate core counts.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mbssoc_rr_picker.sv
// Combinational round-robin picker: finds the first set request bit searching
// upward from (ptr+1) modulo N. Shared with the APIC interrupt dispatcher.
module mbssoc_rr_picker
   import mbssoc_bus_arbiter_pkg::*;
#(
   parameter int N     = ARB_CORE_NUM,
   parameter int IDX_W = idx_width(ARB_CORE_NUM)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] winner
);

   int idx;

   // Walk the N candidates after ptr in wrap-around order; the first hit wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mbssoc_bus_arbiter.sv
// Round-robin arbiter between the CPU cores and the shared RAM port.
// One owner at a time drives the RAM; read data is steered back by a tag.
// Optional feature macro: MBSSOC_ARB_STARVE_CNT_EN adds the starve_max output.
module mbssoc_bus_arbiter
   import mbssoc_bus_arbiter_pkg::*;
#(
   parameter int CORE_NUM   = ARB_CORE_NUM,
   parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
   parameter int DATA_WIDTH = ARB_DATA_WIDTH,
   parameter int MAX_HOLD   = ARB_MAX_HOLD
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [CORE_NUM-1:0]            req,
   input  logic [CORE_NUM-1:0]            lock,
   input  logic [CORE_NUM*ADDR_WIDTH-1:0] core_addr,
   input  logic [CORE_NUM*DATA_WIDTH-1:0] core_wdata,
   input  logic [CORE_NUM-1:0]            core_we,
   input  logic [CORE_NUM-1:0]            core_re,
   output logic [CORE_NUM-1:0]            gnt,
   output logic [DATA_WIDTH-1:0]          core_rdata,
   output logic [CORE_NUM-1:0]            core_rvalid,
   output logic [ADDR_WIDTH-1:0]          ram_addr,
   output logic [DATA_WIDTH-1:0]          ram_wdata,
   output logic                           ram_we,
   output logic                           ram_re,
   input  logic [DATA_WIDTH-1:0]          ram_rdata
`ifdef MBSSOC_ARB_STARVE_CNT_EN
   ,
   output logic [STARVE_WIDTH-1:0]        starve_max
`endif
);

   localparam int IDX_W  = idx_width(CORE_NUM);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);

   arb_state_e            state_q, state_d;
   logic [IDX_W-1:0]      owner_q, owner_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;
   logic [CORE_NUM-1:0]   gnt_q, gnt_d;
   logic                  rd_pend_q;
   logic [IDX_W-1:0]      rd_tag_q;
   logic [CORE_NUM-1:0]   rvalid_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  pick_found;
   logic [IDX_W-1:0]      pick_idx;
   logic                  owner_req;
   logic                  others_req;
   logic                  owner_release;
   logic [ADDR_WIDTH-1:0] owner_addr;
   logic [DATA_WIDTH-1:0] owner_wdata;

   mbssoc_rr_picker #(
      .N     (CORE_NUM),
      .IDX_W (IDX_W)
   ) u_picker (
      .req    (req),
      .ptr    (ptr_q),
      .found  (pick_found),
      .winner (pick_idx)
   );

   assign owner_req   = req[owner_q];
   assign others_req  = |(req & ~gnt_q);
   assign owner_addr  = core_addr[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
   assign owner_wdata = core_wdata[owner_q*DATA_WIDTH +: DATA_WIDTH];

   // Owner gives up the bus when it drops req, or when its hold budget is spent
   // while unlocked and someone else waits; a saturated counter still counts as spent.
   assign owner_release = !owner_req ||
                          ((hold_q >= HOLD_LAST) && !lock[owner_q] && others_req);

   // Next-state logic: every release passes through IDLE so grants never abut.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      case (state_q)
         ARB_IDLE: begin
            gnt_d  = '0;
            hold_d = '0;
            if (pick_found) begin
               state_d = ARB_OWN;
               owner_d = pick_idx;
               gnt_d   = CORE_NUM'(1) << pick_idx;
            end
         end
         ARB_OWN: begin
            if (owner_release) begin
               state_d = ARB_IDLE;
               gnt_d   = '0;
               ptr_d   = owner_q;
               hold_d  = '0;
            end else if (hold_q != HOLD_SAT) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // RAM port mux: only the current owner reaches the RAM, and a write beats a read.
   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      if (state_q == ARB_OWN) begin
         ram_addr  = owner_addr;
         ram_wdata = owner_wdata;
         ram_we    = owner_req & core_we[owner_q];
         ram_re    = owner_req & core_re[owner_q] & ~core_we[owner_q];
      end
   end

   // Arbitration state registers; the pointer starts at the last core so core 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         ptr_q   <= IDX_W'(CORE_NUM - 1);
         hold_q  <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
      end
   end

   // Read return: tag the reader when the strobe goes out, then register the RAM
   // data one cycle later and flag it to the tagged core, even if it lost the bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend_q <= 1'b0;
         rd_tag_q  <= '0;
         rvalid_q  <= '0;
         rdata_q   <= '0;
      end else begin
         rd_pend_q <= ram_re;
         if (ram_re) begin
            rd_tag_q <= owner_q;
         end
         rvalid_q <= rd_pend_q ? (CORE_NUM'(1) << rd_tag_q) : '0;
         if (rd_pend_q) begin
            rdata_q <= ram_rdata;
         end
      end
   end

   assign gnt         = gnt_q;
   assign core_rvalid = rvalid_q;
   assign core_rdata  = rdata_q;

`ifdef MBSSOC_ARB_STARVE_CNT_EN
   logic [STARVE_WIDTH-1:0] wait_q [CORE_NUM];
   logic [STARVE_WIDTH-1:0] starve_q;
   logic [STARVE_WIDTH-1:0] wait_peak;

   // Largest wait currently in progress across all cores.
   always_comb begin
      wait_peak = '0;
      for (int i = 0; i < CORE_NUM; i++) begin
         if (wait_q[i] > wait_peak) begin
            wait_peak = wait_q[i];
         end
      end
   end

   // Per-core wait counters run while requesting without a grant and saturate;
   // the high-water mark only ever grows until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CORE_NUM; i++) begin
            wait_q[i] <= '0;
         end
         starve_q <= '0;
      end else begin
         for (int i = 0; i < CORE_NUM; i++) begin
            if (req[i] && !gnt_q[i]) begin
               if (wait_q[i] != {STARVE_WIDTH{1'b1}}) begin
                  wait_q[i] <= wait_q[i] + STARVE_WIDTH'(1);
               end
            end else begin
               wait_q[i] <= '0;
            end
         end
         if (wait_peak > starve_q) begin
            starve_q <= wait_peak;
         end
      end
   end

   assign starve_max = starve_q;
`endif

endmodule

// File: tb/tb_mbssoc_bus_arbiter.sv
// Self-checking bench for mbssoc_bus_arbiter with two cores and a small RAM model.
// Each table row drives inputs sampled at the next rising edge; outputs are
// compared on the following falling edge while those inputs are still held.
module tb_mbssoc_bus_arbiter;

   localparam int CN = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MH = 16;

   logic            clk;
   logic            rst;
   logic [CN-1:0]   req, lock, core_we, core_re;
   logic [CN*AW-1:0] core_addr;
   logic [CN*DW-1:0] core_wdata;
   logic [CN-1:0]   gnt, core_rvalid;
   logic [DW-1:0]   core_rdata, ram_wdata, ram_rdata;
   logic [AW-1:0]   ram_addr;
   logic            ram_we, ram_re;
`ifdef MBSSOC_ARB_STARVE_CNT_EN
   logic [15:0]     starve_max;
`endif

   logic [DW-1:0]   mem [0:255];

   int checks;
   int failures;

   typedef struct packed {
      logic        rst;
      logic [1:0]  req;
      logic [1:0]  lock;
      logic [1:0]  we;
      logic [1:0]  re;
      logic [31:0] addr0;
      logic [31:0] addr1;
      logic [31:0] wdata0;
      logic [1:0]  e_gnt;
      logic        e_we;
      logic        e_re;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [1:0]  e_rvalid;
      logic        c_rdata;
      logic [31:0] e_rdata;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   mbssoc_bus_arbiter #(
      .CORE_NUM   (CN),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MAX_HOLD   (MH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .lock        (lock),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .core_we     (core_we),
      .core_re     (core_re),
      .gnt         (gnt),
      .core_rdata  (core_rdata),
      .core_rvalid (core_rvalid),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_we      (ram_we),
      .ram_re      (ram_re),
      .ram_rdata   (ram_rdata)
`ifdef MBSSOC_ARB_STARVE_CNT_EN
      ,
      .starve_max  (starve_max)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM model: one-cycle read latency, write on strobe.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_addr[7:0]];
   end

   task automatic driveInputs(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                              input logic [1:0] we, input logic [1:0] re,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] wd0);
      rst        = r;
      req        = rq;
      lock       = lk;
      core_we    = we;
      core_re    = re;
      core_addr  = {a1, a0};
      core_wdata = {~wd0, wd0};
   endtask

   task automatic stepCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input vec_t v);
      driveInputs(v.rst, v.req, v.lock, v.we, v.re, v.addr0, v.addr1, v.wdata0);
      stepCycle();
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 32'hDEAD_BEEF;
      mem[8'h20] = 32'h1234_5678;
      ram_rdata  = '0;

      // Fields: rst req lock we re addr0 addr1 wdata0 | gnt we re addr wdata rvalid chk_rdata rdata
      vecs[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b00, 1'b0, 1'b0, 32'h0,  32'h0,         2'b00, 1'b1, 32'h0};
      vecs[1]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 32'h10, 32'h0,  32'h0,         2'b01, 1'b0, 1'b1, 32'h10, 32'h0,         2'b00, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 32'h10, 32'h0,  32'h0,         2'b01, 1'b0, 1'b1, 32'h10, 32'h0,         2'b00, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 32'h10, 32'h0,  32'h0,         2'b00, 1'b0, 1'b0, 32'h0,  32'h0,         2'b01, 1'b1, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b00, 1'b0, 1'b0, 32'h0,  32'h0,         2'b00, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 32'h30, 32'h0,  32'hCAFE_F00D, 2'b01, 1'b1, 1'b0, 32'h30, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 32'h30, 32'h0,  32'hCAFE_F00D, 2'b01, 1'b1, 1'b0, 32'h30, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b00, 1'b0, 1'b0, 32'h0,  32'h0,         2'b00, 1'b0, 32'h0};
      vecs[8]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b00, 1'b0, 1'b0, 32'h0,  32'h0,         2'b00, 1'b1, 32'h0};
      vecs[9]  = '{1'b0, 2'b11, 2'b00, 2'b10, 2'b01, 32'h10, 32'h20, 32'h0,         2'b01, 1'b0, 1'b1, 32'h10, 32'h0,         2'b00, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 2'b11, 2'b00, 2'b10, 2'b01, 32'h10, 32'h20, 32'h0,         2'b01, 1'b0, 1'b1, 32'h10, 32'h0,         2'b00, 1'b0, 32'h0};
      vecs[11] = '{1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 32'h0,  32'h20, 32'h0,         2'b00, 1'b0, 1'b0, 32'h0,  32'h0,         2'b01, 1'b1, 32'hDEAD_BEEF};
      vecs[12] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b00, 1'b0, 1'b0, 32'h0,  32'h0,         2'b00, 1'b0, 32'h0};
      vecs[13] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b00, 1'b0, 1'b0, 32'h0,  32'h0,         2'b00, 1'b1, 32'h0};
      vecs[14] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b01, 1'b0, 1'b0, 32'h0,  32'h0,         2'b00, 1'b0, 32'h0};
      vecs[15] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b01, 1'b0, 1'b0, 32'h0,  32'h0,         2'b00, 1'b0, 32'h0};
      vecs[16] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b01, 1'b0, 1'b0, 32'h0,  32'h0,         2'b00, 1'b0, 32'h0};
      vecs[17] = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b00, 1'b0, 1'b0, 32'h0,  32'h0,         2'b00, 1'b0, 32'h0};
      vecs[18] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b10, 1'b0, 1'b0, 32'h0,  32'hFFFF_FFFF, 2'b00, 1'b0, 32'h0};
      vecs[19] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b10, 1'b0, 1'b0, 32'h0,  32'hFFFF_FFFF, 2'b00, 1'b0, 32'h0};
      vecs[20] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b10, 1'b0, 1'b0, 32'h0,  32'hFFFF_FFFF, 2'b00, 1'b0, 32'h0};
      vecs[21] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b00, 1'b0, 1'b0, 32'h0,  32'h0,         2'b00, 1'b0, 32'h0};
      vecs[22] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,         2'b01, 1'b0, 1'b0, 32'h0,  32'h0,         2'b00, 1'b0, 32'h0};

      driveInputs(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Table-driven vectors: read path, write-beats-read, non-owner write, alternation.
      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d_gnt", i),    64'(gnt),         64'(vecs[i].e_gnt));
         checkOutput($sformatf("v%0d_we", i),     64'(ram_we),      64'(vecs[i].e_we));
         checkOutput($sformatf("v%0d_re", i),     64'(ram_re),      64'(vecs[i].e_re));
         checkOutput($sformatf("v%0d_addr", i),   64'(ram_addr),    64'(vecs[i].e_addr));
         checkOutput($sformatf("v%0d_wdata", i),  64'(ram_wdata),   64'(vecs[i].e_wdata));
         checkOutput($sformatf("v%0d_rvalid", i), 64'(core_rvalid), 64'(vecs[i].e_rvalid));
         if (vecs[i].c_rdata)
            checkOutput($sformatf("v%0d_rdata", i), 64'(core_rdata), 64'(vecs[i].e_rdata));
      end
      checkOutput("mem30_written", 64'(mem[8'h30]), 64'(32'hCAFE_F00D));
      checkOutput("mem20_untouched", 64'(mem[8'h20]), 64'(32'h1234_5678));

      // Forced rotation after MAX_HOLD cycles, then rotation back with pointer wrap.
      driveInputs(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      stepCycle();
      driveInputs(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      for (int c = 1; c <= 36; c++) begin
         logic [1:0] expGnt;
         stepCycle();
         if (c <= MH)               expGnt = 2'b01;
         else if (c == MH + 1)      expGnt = 2'b00;
         else if (c <= 2 * MH + 1)  expGnt = 2'b10;
         else if (c == 2 * MH + 2)  expGnt = 2'b00;
         else                       expGnt = 2'b01;
         checkOutput($sformatf("hold_c%0d_gnt", c), 64'(gnt), 64'(expGnt));
      end

      // Locked owner is never rotated; the waiter gets the bus two cycles after release.
      driveInputs(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      stepCycle();
      driveInputs(1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      for (int c = 1; c <= 40; c++) begin
         stepCycle();
         checkOutput($sformatf("lock_c%0d_gnt", c), 64'(gnt), 64'(2'b01));
      end
      driveInputs(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      stepCycle();
      checkOutput("lock_release_gap", 64'(gnt), 64'(2'b00));
      stepCycle();
      checkOutput("lock_next_owner", 64'(gnt), 64'(2'b10));

      // Reset right after a read strobe cancels the pending read return.
      driveInputs(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      stepCycle();
      driveInputs(1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 32'h10, 32'h0, 32'h0);
      stepCycle();
      checkOutput("rstrd_gnt", 64'(gnt), 64'(2'b01));
      checkOutput("rstrd_re", 64'(ram_re), 64'(1'b1));
      stepCycle();
      checkOutput("rstrd_re_held", 64'(ram_re), 64'(1'b1));
      driveInputs(1'b1, 2'b01, 2'b00, 2'b00, 2'b01, 32'h10, 32'h0, 32'h0);
      stepCycle();
      checkOutput("rstrd_gnt_cleared", 64'(gnt), 64'(2'b00));
      checkOutput("rstrd_rvalid_cleared", 64'(core_rvalid), 64'(2'b00));
      checkOutput("rstrd_re_cleared", 64'(ram_re), 64'(1'b0));
      checkOutput("rstrd_we_cleared", 64'(ram_we), 64'(1'b0));
      driveInputs(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      stepCycle();
      checkOutput("rstrd_rvalid_after", 64'(core_rvalid), 64'(2'b00));
      checkOutput("rstrd_gnt_after", 64'(gnt), 64'(2'b00));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mbssoc_bus_arbiter.md
Name: mbssoc_bus_arbiter

Overview:
- Round-robin arbiter between the CPU cores and the shared RAM port of the SoC.
- Placed directly upstream of the RAM.
- Each core gets a private request/address/data/control channel. The arbiter drives exactly one owner's transaction onto the RAM port and steers the 1-cycle-latency RAM read data back to that owner.
- Replaces direct multi-driver tristate sharing of data_bus/addr_bus/ctrl_bus.

Parameters:
- CORE_NUM, 2, number of requesting cores (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- MAX_HOLD, 16, max consecutive owned cycles before forced rotation when another core waits (>=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  CORE_NUM  per-core bus request, level, held until done.
- lock  in  CORE_NUM  per-core lock; owner with lock set is exempt from MAX_HOLD rotation.
- core_addr  in  CORE_NUM*ADDR_WIDTH  flattened per-core address, core i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- core_wdata  in  CORE_NUM*DATA_WIDTH  flattened per-core write data.
- core_we  in  CORE_NUM  per-core write enable.
- core_re  in  CORE_NUM  per-core read enable.
- gnt  out  CORE_NUM  one-hot (or zero) registered grant.
- core_rdata  out  DATA_WIDTH  RAM read data, broadcast to all cores.
- core_rvalid  out  CORE_NUM  one-hot, read data valid for that core.
- ram_addr  out  ADDR_WIDTH  address to RAM.
- ram_wdata  out  DATA_WIDTH  write data to RAM.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_re.

Behaviour:
- Reset: gnt=0, core_rvalid=0, core_rdata=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, state=IDLE, rr pointer=CORE_NUM-1 (so core 0 wins first), hold counter=0, pending-read tag cleared. Reset mid-transaction aborts it; a read issued the cycle before reset returns no rvalid.
- FSM states:
  - IDLE: gnt=0. If any req, register gnt for the first requester searching from (ptr+1) mod CORE_NUM upward; go to OWN. Latency from req rise to gnt is 1 cycle.
  - OWN: RAM port = owner's addr/wdata, we/re gated by gnt (combinational mux on registered owner index). Hold counter increments each cycle, saturating at MAX_HOLD.
  - OWN exit, owner req low: gnt drops next cycle, ptr=owner, go to IDLE. The owner's we/re are ignored in the cycle req is low.
  - OWN exit, hold counter==MAX_HOLD-1 and lock[owner]=0 and any other req high: forced release. gnt=0 for exactly one cycle (IDLE), ptr=owner, counter cleared; the next owner is chosen by rr search.
  - If no other core is requesting, or lock[owner]=1, the owner keeps the bus indefinitely.
- Simultaneous events:
  - Release and forced rotation in the same cycle are treated as release.
  - A new req arriving on the same cycle another drops waits for the IDLE cycle; there is no back-to-back grant without an IDLE gap.
- Non-owner we/re never reach RAM; RAM outputs are 0 when gnt=0.
- ram_we and ram_re both high from the owner: the write wins, ram_re is forced 0. This is a protocol error.
- Read return:
  - On ram_re, owner index is tagged.
  - Next cycle core_rvalid[tag]=1 for one cycle and core_rdata=ram_rdata (registered), even if the grant was released meanwhile.
- Pointer wrap: search order is modulo CORE_NUM; ptr=CORE_NUM-1 wraps to core 0.

Optional Feature:
- MBSSOC_ARB_STARVE_CNT_EN defined:
  - Adds output starve_max (16 bits): the largest number of cycles any core has had req high without gnt since reset.
  - Per-core wait counters clear on grant and saturate at 16'hFFFF.
  - starve_max resets to 0.
- Undefined: port and counters are absent; no other behaviour changes.

Decomposition:
- Shared package/include holds the existing width constants, CORE_NUM, MAX_HOLD default, FSM state encodings (ARB_IDLE=1'b0, ARB_OWN=1'b1), and a CORE_IDX_WIDTH=clog2(CORE_NUM) constant.
- One natural sub-module: mbssoc_rr_picker. It is combinational and takes req vector plus ptr, returning found flag and winner index. It is reused later by the APIC interrupt dispatcher.

Test Plan:
- Reset, then req=2'b01, core0 reads addr 0x10 (RAM holds 0xDEADBEEF) -> gnt=01 one cycle after req; ram_re=1 with ram_addr=0x10; next cycle core_rvalid=01, core_rdata=0xDEADBEEF.
- req=2'b11 both continuously, each dropping req after 3 cycles owned -> grant order 01,IDLE,10,IDLE,01; never both bits set.
- core0 holds req for 40 cycles, core1 req high, lock=0, MAX_HOLD=16 -> core0 owns exactly 16 cycles, one IDLE cycle, gnt=10.
- Same as above with lock[0]=1 -> core0 keeps gnt all 40 cycles; core1 granted 2 cycles after core0 drops req.
- Non-owner core1 asserts core_we with addr 0x20 while core0 owns and reads -> ram_we stays 0, RAM[0x20] unchanged.
- rst asserted the cycle after core0's ram_re -> next cycle gnt=0, core_rvalid=0, all RAM strobes 0.
